// File: rtl/countdown_timer_if.sv
// Control and six-digit BCD display bundle for the countdown timer.
interface countdown_timer_if;
  logic       start;
  logic       load;
  logic       quick;
  logic [3:0] set_min_10;
  logic [3:0] set_min_1;
  logic [3:0] set_sec_10;
  logic [3:0] set_sec_1;
  logic [3:0] min_10;
  logic [3:0] min_1;
  logic [3:0] sec_10;
  logic [3:0] sec_1;
  logic [3:0] milli_10;
  logic [3:0] milli_1;
  logic       running;
  logic       alarm;

  modport master (
    output start, load, quick,
    output set_min_10, set_min_1,
    output set_sec_10, set_sec_1,
    input  min_10, min_1, sec_10, sec_1,
    input  milli_10, milli_1,
    input  running, alarm
  );

  modport slave (
    input  start, load, quick,
    input  set_min_10, set_min_1,
    input  set_sec_10, set_sec_1,
    output min_10, min_1, sec_10, sec_1,
    output milli_10, milli_1,
    output running, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS.cc countdown with pause, preset load and timed alarm.
// Count is kept as six BCD digits and decremented by a borrow chain.
module countdown_timer #(
  parameter int TICK_DIV    = 500000,
  parameter int QUICK_DIV   = 2,
  parameter int ALARM_TICKS = 100
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int DMAX =
    (TICK_DIV > QUICK_DIV) ? TICK_DIV : QUICK_DIV;
  localparam int PW = $clog2(DMAX) + 1;
  localparam int AW = $clog2(ALARM_TICKS) + 1;

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, ALARM
  } state_e;

  state_e        state_q, state_d;
  logic          start_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          running_q, alarm_q;

  logic          st_edge;
  logic          tick;
  logic          cnt_zero;
  logic          last_cs;
  logic [PW-1:0] lim_m1;
  logic [23:0]   preset;
  logic [23:0]   cnt_dec;

  function automatic logic [3:0] clamp(
    input logic [3:0] d,
    input logic [3:0] mx
  );
    return (d > mx) ? mx : d;
  endfunction

  // digit 0 = milli_1 ... digit 5 = min_10; sec_10 wraps to 5
  function automatic logic [23:0] dec_bcd(
    input logic [23:0] c
  );
    logic [23:0] r;
    logic        b;
    r = c;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign st_edge  = bus.start & ~start_q;
  assign cnt_zero = (cnt_q == 24'h000000);
  assign last_cs  = (cnt_q == 24'h000001);
  assign cnt_dec  = dec_bcd(cnt_q);

  assign lim_m1 = bus.quick ? PW'(QUICK_DIV - 1)
                            : PW'(TICK_DIV - 1);

  // >= so a mid-count switch to a shorter limit ticks at once
  assign tick = ((state_q == RUN) || (state_q == ALARM))
              && (presc_q >= lim_m1);

  assign preset = {
    clamp(bus.set_min_10, 4'd9),
    clamp(bus.set_min_1,  4'd9),
    clamp(bus.set_sec_10, 4'd5),
    clamp(bus.set_sec_1,  4'd9),
    8'h00
  };

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.load) begin
          cnt_d = preset;
        end else if (st_edge && !cnt_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (st_edge) begin
          state_d = PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (!cnt_zero) cnt_d = cnt_dec;
          if (last_cs) begin
            state_d = ALARM;
            acnt_d  = '0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (bus.load) begin
          cnt_d   = preset;
          presc_d = '0;
          state_d = IDLE;
        end else if (st_edge) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        cnt_d = '0;
        if (st_edge) begin
          state_d = IDLE;
        end else if (tick) begin
          presc_d = '0;
          acnt_d  = acnt_q + AW'(1);
          if (acnt_q == AW'(ALARM_TICKS - 1)) begin
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      presc_q   <= '0;
      acnt_q    <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      presc_q   <= presc_d;
      acnt_q    <= acnt_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign bus.min_10   = cnt_q[23:20];
  assign bus.min_1    = cnt_q[19:16];
  assign bus.sec_10   = cnt_q[15:12];
  assign bus.sec_1    = cnt_q[11:8];
  assign bus.milli_10 = cnt_q[7:4];
  assign bus.milli_1  = cnt_q[3:0];
  assign bus.running  = running_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: load, borrow, pause, alarm, reset.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  countdown_timer_if ifc ();

  countdown_timer #(
    .TICK_DIV    (4),
    .QUICK_DIV   (2),
    .ALARM_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] disp();
    return {ifc.min_10, ifc.min_1, ifc.sec_10,
            ifc.sec_1, ifc.milli_10, ifc.milli_1};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [23:0] obs,
    input logic [23:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic ld(
    input logic [3:0] m10, m1, s10, s1
  );
    ifc.set_min_10 = m10;
    ifc.set_min_1  = m1;
    ifc.set_sec_10 = s10;
    ifc.set_sec_1  = s1;
    ifc.load = 1'b1;
    step(1);
    ifc.load = 1'b0;
  endtask

  // edge sampled on the first clock, released on the second
  task automatic press();
    ifc.start = 1'b1;
    step(1);
    ifc.start = 1'b0;
    step(1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.load  = 1'b0;
    ifc.quick = 1'b0;
    ifc.set_min_10 = 4'd0;
    ifc.set_min_1  = 4'd0;
    ifc.set_sec_10 = 4'd0;
    ifc.set_sec_1  = 4'd0;
    #2;
    chk("rst_disp", disp(), 24'h000000);
    chk("rst_run", {23'd0, ifc.running}, 24'd0);
    chk("rst_alarm", {23'd0, ifc.alarm}, 24'd0);
    step(1);
    reset = 1'b0;
    step(1);

    // 00:01 -> 100 ticks of 4 clk
    ld(4'd0, 4'd0, 4'd0, 4'd1);
    chk("ld_0001", disp(), 24'h000100);
    press();
    chk("run_hi", {23'd0, ifc.running}, 24'd1);
    step(2);
    chk("pre_tick", disp(), 24'h000100);
    step(1);
    chk("tick1", disp(), 24'h000099);
    step(395);
    chk("e399_disp", disp(), 24'h000001);
    chk("e399_alarm", {23'd0, ifc.alarm}, 24'd0);
    step(1);
    chk("e400_alarm", {23'd0, ifc.alarm}, 24'd1);
    chk("e400_run", {23'd0, ifc.running}, 24'd0);
    chk("e400_disp", disp(), 24'h000000);
    press();
    chk("ack_alarm", {23'd0, ifc.alarm}, 24'd0);
    chk("ack_run", {23'd0, ifc.running}, 24'd0);

    press();
    chk("zero_start", {23'd0, ifc.running}, 24'd0);

    ld(4'd0, 4'd0, 4'd7, 4'd12);
    chk("clamp_sec", disp(), 24'h005900);
    ld(4'd12, 4'd15, 4'd3, 4'd0);
    chk("clamp_min", disp(), 24'h993000);

    ld(4'd1, 4'd0, 4'd0, 4'd0);
    chk("ld_1000", disp(), 24'h100000);
    press();
    step(3);
    chk("borrow_min", disp(), 24'h095999);
    press();
    chk("pause0", {23'd0, ifc.running}, 24'd0);
    ld(4'd0, 4'd0, 4'd1, 4'd0);
    chk("pause_ld", disp(), 24'h001000);
    chk("pause_ld_idle", {23'd0, ifc.running}, 24'd0);
    press();
    step(3);
    chk("borrow_sec", disp(), 24'h000999);
    ld(4'd5, 4'd5, 4'd5, 4'd5);
    chk("run_ld_ign", disp(), 24'h000999);
    chk("run_ld_run", {23'd0, ifc.running}, 24'd1);

    // pause with prescaler at 2
    step(1);
    press();
    chk("pause_run", {23'd0, ifc.running}, 24'd0);
    step(50);
    chk("pause_hold", disp(), 24'h000999);
    press();
    chk("resume_run", {23'd0, ifc.running}, 24'd1);
    chk("resume_1", disp(), 24'h000999);
    step(1);
    chk("resume_2", disp(), 24'h000998);

    // edge lands on the tick edge
    step(3);
    press();
    chk("coin_disp", disp(), 24'h000998);
    chk("coin_run", {23'd0, ifc.running}, 24'd0);
    step(10);
    chk("coin_hold", disp(), 24'h000998);

    // async reset between edges mid-RUN
    ld(4'd0, 4'd1, 4'd3, 4'd0);
    chk("ld_0130", disp(), 24'h013000);
    press();
    step(5);
    chk("run_0130", disp(), 24'h012999);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_disp", disp(), 24'h000000);
    chk("arst_run", {23'd0, ifc.running}, 24'd0);
    chk("arst_alarm", {23'd0, ifc.alarm}, 24'd0);
    step(1);
    reset = 1'b0;
    step(1);

    // quick mode: alarm lasts 3 ticks of 2 clk
    ifc.quick = 1'b1;
    ld(4'd0, 4'd0, 4'd0, 4'd1);
    press();
    step(198);
    chk("q_e199", {23'd0, ifc.alarm}, 24'd0);
    chk("q_e199_d", disp(), 24'h000001);
    step(1);
    chk("q_e200", {23'd0, ifc.alarm}, 24'd1);
    step(5);
    chk("q_e205", {23'd0, ifc.alarm}, 24'd1);
    step(1);
    chk("q_e206", {23'd0, ifc.alarm}, 24'd0);
    chk("q_e206_r", {23'd0, ifc.running}, 24'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the stopwatch: loads a BCD preset (MM:SS), counts down in centiseconds and raises an alarm at 00:00.00.
- Count is held directly as six BCD digits and decremented with a borrow chain; no binary-to-BCD conversion.
- Drives the same six-digit display path as the stopwatch and shares the start/quick button conventions.

Parameters:
TICK_DIV, 500000, clk cycles per centisecond tick in normal mode (100 Hz at 50 MHz)
QUICK_DIV, 2, clk cycles per tick when quick=1 (simulation/demo speed-up)
ALARM_TICKS, 100, ticks the alarm stays asserted before auto-return to IDLE

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  button level; each rising edge is one start/pause/acknowledge event
load  input  1  level; loads preset digits when permitted (see Behaviour)
quick  input  1  selects QUICK_DIV instead of TICK_DIV
set_min_10  input  4  preset minutes tens (BCD)
set_min_1  input  4  preset minutes units (BCD)
set_sec_10  input  4  preset seconds tens (BCD)
set_sec_1  input  4  preset seconds units (BCD)
min_10, min_1, sec_10, sec_1, milli_10, milli_1  output  4 each  current count, BCD, registered
running  output  1  high in RUN only
alarm  output  1  high in ALARM only

Behaviour:
- Reset (async): all digits 0, state IDLE, running=0, alarm=0, prescaler=0, alarm tick counter=0, start edge register=0.
- Start edge: start_q registered each clk; edge = start & ~start_q. One event per press; held level gives no repeat.
- Tick: prescaler counts clk in RUN and ALARM; tick when prescaler >= limit-1 (limit = quick ? QUICK_DIV : TICK_DIV), prescaler cleared on tick. Changing quick mid-count: if prescaler already >= new limit-1, tick on next cycle.
- Preset load: min_10/min_1/sec_1 values >9 clamp to 9; set_sec_10 >5 clamps to 5; milli_10/milli_1 load 0. Outputs show the preset the cycle after load is sampled.
- States:
  IDLE: load -> load preset. edge with count != 0 -> RUN, prescaler cleared. edge with count == 0 -> stay IDLE. load and edge in same cycle: load wins, stay IDLE.
  RUN: tick -> decrement by 1 centisecond. If the decrement reaches 00:00.00 -> ALARM next cycle, alarm counter cleared. edge -> PAUSE; edge and tick in same cycle: PAUSE, no decrement. load ignored.
  PAUSE: prescaler held (not cleared). edge -> RUN, continuing from held prescaler. load -> load preset, prescaler cleared, -> IDLE.
  ALARM: digits stay 0. Each tick increments the alarm counter; on ALARM_TICKS-th tick -> IDLE. edge -> IDLE immediately (acknowledge). load ignored.
- Decrement borrow chain: milli_1 0->9 borrows milli_10; milli_10 0->9 borrows sec_1; sec_1 0->9 borrows sec_10; sec_10 0->5 borrows min_1; min_1 0->9 borrows min_10. Count never goes below 00:00.00. Maximum preset is 99:59.00.
- Latency: digit outputs change the clk edge after the tick condition. running/alarm are registered from state and change with the state transition.

Test Plan:
- Reset mid-RUN with preset 01:30 and reset pulsed asynchronously between edges -> all digits 0, IDLE, running=0, alarm=0 immediately.
- TICK_DIV=4, load 00:01, start edge -> running=1; display 00:00.99 after 4 clk; alarm=1 exactly 400 clk after start (100 ticks); running=0.
- Borrow chain: load 10:00, start, one tick -> 09:59.99; load 00:10, one tick -> 00:09.99.
- Pause/resume: RUN with prescaler at 2 (TICK_DIV=4), edge -> PAUSE; hold 50 clk, digits unchanged; edge -> next tick 2 clk later. Edge coincident with tick -> no decrement.
- Clamping and guards: load set_sec_10=7, set_sec_1=12 -> 00:59.00 shown; start edge with count 00:00.00 -> stays IDLE; load during RUN -> ignored.
- ALARM exit: ALARM_TICKS=3, QUICK_DIV=2 with quick=1 -> alarm high for 6 clk, then IDLE. Separate run: start edge during ALARM -> alarm=0 next cycle.
